// File: rtl/weight_buffer_writer.sv
// Scatters a flat stream of weight words column-wise into ARRAY_M weight bank
// write ports: word k lands in bank k mod num_cols at base_addr + k div num_cols.
module weight_buffer_writer #(
  parameter int ADDR_WIDTH        = 16,
  parameter int ARRAY_M           = 8,
  parameter int DATA_WIDTH        = 8,
  parameter int CONCAT_ADDR_WIDTH = ADDR_WIDTH*ARRAY_M,
  parameter int CONCAT_DATA_WIDTH = DATA_WIDTH*ARRAY_M
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [$clog2(ARRAY_M):0]       num_cols,
  input  logic [ADDR_WIDTH-1:0]          num_rows,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [CONCAT_ADDR_WIDTH-1:0]   wr_addr,
  output logic [CONCAT_DATA_WIDTH-1:0]   wr_data,
  output logic [ARRAY_M-1:0]             wr_en,
  output logic                           busy,
  output logic                           done
);
  localparam int NCW = $clog2(ARRAY_M) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t                   r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]    r_base, r_rows, r_row;
  logic [NCW-1:0]           r_cols, r_col;
  logic [NCW-1:0]           w_cols_clamped;
  logic                     w_accept, w_last_col, w_last_row, w_zero_cfg;
  logic [ARRAY_M-1:0]       r_wr_en;
  logic [CONCAT_ADDR_WIDTH-1:0] r_wr_addr;
  logic [CONCAT_DATA_WIDTH-1:0] r_wr_data;

  assign w_cols_clamped = (num_cols > NCW'(ARRAY_M)) ? NCW'(ARRAY_M) : num_cols;
  assign w_zero_cfg     = (w_cols_clamped == '0) || (num_rows == '0);
  assign w_accept       = s_valid && s_ready;
  assign w_last_col     = (r_col == r_cols - NCW'(1));
  assign w_last_row     = (r_row == r_rows - ADDR_WIDTH'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_zero_cfg ? S_DONE : S_WRITE;
      S_WRITE: if (w_accept && w_last_col && w_last_row) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_cols    <= '0;
      r_rows    <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_wr_en   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start) begin
        r_base <= base_addr;
        r_cols <= w_cols_clamped;
        r_rows <= num_rows;
        r_col  <= '0;
        r_row  <= '0;
      end else if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + ADDR_WIDTH'(1);
        end else begin
          r_col <= r_col + NCW'(1);
        end
      end
      // Write ports are one-hot per cycle; idle lanes are forced to zero.
      r_wr_en   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      if (w_accept) begin
        for (int m = 0; m < ARRAY_M; m++) begin
          if (r_col == NCW'(m)) begin
            r_wr_en[m]                           <= 1'b1;
            r_wr_addr[m*ADDR_WIDTH +: ADDR_WIDTH] <= r_base + r_row;
            r_wr_data[m*DATA_WIDTH +: DATA_WIDTH] <= s_data;
          end
        end
      end
    end
  end

  assign s_ready = (r_state == S_WRITE);
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_weight_buffer_writer.sv
// Cycle-by-cycle directed vectors for weight_buffer_writer: each record holds the
// inputs for one clock edge and the outputs expected just after that edge.
module tb_weight_buffer_writer;
  logic         clk = 1'b0;
  logic         reset, start, s_valid;
  logic [15:0]  base_addr, num_rows;
  logic [3:0]   num_cols;
  logic [7:0]   s_data;
  logic         s_ready, busy, done;
  logic [127:0] wr_addr;
  logic [63:0]  wr_data;
  logic [7:0]   wr_en;

  int n_vec = 0;
  int n_err = 0;

  weight_buffer_writer #(.ADDR_WIDTH(16), .ARRAY_M(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_cols(num_cols), .num_rows(num_rows), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic [15:0] base;
    logic [3:0]  cols;
    logic [15:0] rows;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        busy;
    logic        done;
    logic [7:0]  en;
    logic [15:0] addr;
    logic [7:0]  edata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic st, input logic [15:0] b,
                              input logic [3:0] c, input logic [15:0] r, input logic v,
                              input logic [7:0] d, input logic rdy, input logic bsy,
                              input logic dn, input logic [7:0] en, input logic [15:0] a,
                              input logic [7:0] ed);
    vec_t x;
    x.rst = rst; x.start = st; x.base = b; x.cols = c; x.rows = r; x.valid = v; x.data = d;
    x.ready = rdy; x.busy = bsy; x.done = dn; x.en = en; x.addr = a; x.edata = ed;
    return x;
  endfunction

  // Drive one vector's inputs, clock once, then compare outputs 1 ns after the edge.
  task automatic apply(input vec_t v, input string name);
    logic [127:0] exp_a;
    logic [63:0]  exp_d;
    reset = v.rst; start = v.start; base_addr = v.base; num_cols = v.cols;
    num_rows = v.rows; s_valid = v.valid; s_data = v.data;
    @(posedge clk); #1;
    exp_a = '0;
    exp_d = '0;
    for (int m = 0; m < 8; m++)
      if (v.en[m]) begin
        exp_a[m*16 +: 16] = v.addr;
        exp_d[m*8 +: 8]   = v.edata;
      end
    n_vec++;
    if (s_ready !== v.ready || busy !== v.busy || done !== v.done || wr_en !== v.en ||
        wr_addr !== exp_a || wr_data !== exp_d) begin
      n_err++;
      $display("FAIL %s #%0d: got ready=%0b busy=%0b done=%0b en=%h addr=%h data=%h; want ready=%0b busy=%0b done=%0b en=%h addr=%h data=%h",
               name, n_vec, s_ready, busy, done, wr_en, wr_addr, wr_data,
               v.ready, v.busy, v.done, v.en, exp_a, exp_d);
    end
  endtask

  initial begin
    // Reset state
    tbl.push_back(mk(1,0,16'h1234,4'd3,16'd3,1,8'hAA, 0,0,0,8'h00,16'h0,8'h0));
    tbl.push_back(mk(1,1,16'h1234,4'd3,16'd3,1,8'hAA, 0,0,0,8'h00,16'h0,8'h0));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,0,8'h00, 0,0,0,8'h00,16'h0,8'h0));

    // Basic fill: 8 cols x 2 rows at 0x0010; config inputs scrambled after start.
    tbl.push_back(mk(0,1,16'h0010,4'd8,16'd2,0,8'hEE, 1,1,0,8'h00,16'h0,8'h0));
    for (int k = 0; k < 16; k++)
      tbl.push_back(mk(0,0,16'hDEAD,4'd1,16'd9,1,8'(k),
                       (k != 15),1,(k == 15),8'(1 << (k % 8)),16'h0010 + 16'(k / 8),8'(k)));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'hEE, 0,0,0,8'h00,16'h0,8'h0));

    // Partial columns + backpressure: 3 cols x 2 rows at 0x0200.
    tbl.push_back(mk(0,1,16'h0200,4'd3,16'd2,0,8'hEE, 1,1,0,8'h00,16'h0000,8'h00));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'hA0, 1,1,0,8'h01,16'h0200,8'hA0));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,0,8'hEE, 1,1,0,8'h00,16'h0000,8'h00));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'hA1, 1,1,0,8'h02,16'h0200,8'hA1));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'hA2, 1,1,0,8'h04,16'h0200,8'hA2));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,0,8'hEE, 1,1,0,8'h00,16'h0000,8'h00));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'hA3, 1,1,0,8'h01,16'h0201,8'hA3));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'hA4, 1,1,0,8'h02,16'h0201,8'hA4));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,0,8'hEE, 1,1,0,8'h00,16'h0000,8'h00));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'hA5, 0,1,1,8'h04,16'h0201,8'hA5));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'hA6, 0,0,0,8'h00,16'h0000,8'h00));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,0,8'h00, 0,0,0,8'h00,16'h0000,8'h00));

    // Zero rows, then zero cols: straight to DONE, no strobes.
    tbl.push_back(mk(0,1,16'h0055,4'd4,16'd0,1,8'h11, 0,1,1,8'h00,16'h0,8'h0));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'h12, 0,0,0,8'h00,16'h0,8'h0));
    tbl.push_back(mk(0,1,16'h0055,4'd0,16'd5,1,8'h13, 0,1,1,8'h00,16'h0,8'h0));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'h14, 0,0,0,8'h00,16'h0,8'h0));

    // Address wrap: 1 col x 3 rows from 0xFFFF.
    tbl.push_back(mk(0,1,16'hFFFF,4'd1,16'd3,0,8'h00, 1,1,0,8'h00,16'h0000,8'h00));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'h31, 1,1,0,8'h01,16'hFFFF,8'h31));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'h32, 1,1,0,8'h01,16'h0000,8'h32));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'h33, 0,1,1,8'h01,16'h0001,8'h33));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'h34, 0,0,0,8'h00,16'h0000,8'h00));

    // Clamp: num_cols=15 behaves as 8, one row at 0x0040.
    tbl.push_back(mk(0,1,16'h0040,4'd15,16'd1,0,8'h00, 1,1,0,8'h00,16'h0,8'h0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'h50 + 8'(k),
                       (k != 7),1,(k == 7),8'(1 << k),16'h0040,8'h50 + 8'(k)));
    tbl.push_back(mk(0,0,16'h0000,4'd0,16'd0,1,8'h5F, 0,0,0,8'h00,16'h0,8'h0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "table");

    // Reset mid-transfer: 5 of 16 beats, then reset with a beat offered.
    apply(mk(0,1,16'h0300,4'd8,16'd2,0,8'h00, 1,1,0,8'h00,16'h0,8'h0), "rst_start");
    for (int k = 0; k < 5; k++)
      apply(mk(0,0,16'h0000,4'd0,16'd0,1,8'h60 + 8'(k), 1,1,0,8'(1 << k),16'h0300,8'h60 + 8'(k)), "rst_beat");
    apply(mk(1,0,16'h0000,4'd0,16'd0,1,8'h65, 0,0,0,8'h00,16'h0,8'h0), "rst_assert");
    apply(mk(0,0,16'h0000,4'd0,16'd0,1,8'h66, 0,0,0,8'h00,16'h0,8'h0), "rst_idle");
    apply(mk(0,1,16'h0100,4'd8,16'd2,0,8'h00, 1,1,0,8'h00,16'h0,8'h0), "rst_restart");
    apply(mk(0,0,16'h0000,4'd0,16'd0,1,8'h77, 1,1,0,8'h01,16'h0100,8'h77), "rst_first");
    apply(mk(0,0,16'h0000,4'd0,16'd0,1,8'h78, 1,1,0,8'h02,16'h0100,8'h78), "rst_second");
    apply(mk(1,0,16'h0000,4'd0,16'd0,0,8'h00, 0,0,0,8'h00,16'h0,8'h0), "rst_again");

    // Start ignored while busy, including during the DONE cycle.
    apply(mk(0,1,16'h0400,4'd2,16'd2,0,8'h00, 1,1,0,8'h00,16'h0,8'h0), "ign_start");
    apply(mk(0,1,16'h0500,4'd1,16'd1,1,8'h81, 1,1,0,8'h01,16'h0400,8'h81), "ign_b0");
    apply(mk(0,0,16'h0000,4'd0,16'd0,1,8'h82, 1,1,0,8'h02,16'h0400,8'h82), "ign_b1");
    apply(mk(0,1,16'h0500,4'd1,16'd1,1,8'h83, 1,1,0,8'h01,16'h0401,8'h83), "ign_b2");
    apply(mk(0,0,16'h0000,4'd0,16'd0,1,8'h84, 0,1,1,8'h02,16'h0401,8'h84), "ign_b3");
    apply(mk(0,1,16'h0600,4'd2,16'd2,1,8'h85, 0,0,0,8'h00,16'h0,8'h0), "ign_done");
    apply(mk(0,0,16'h0000,4'd0,16'd0,1,8'h86, 0,0,0,8'h00,16'h0,8'h0), "ign_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
